sram_arbiter: RTL and testbench

//  Shares the single SRAM port among N_REQ requesters (send, scoring, loader).

---
 rtl/p3p_pkg.sv | 16 +
 rtl/sram_arbiter_rr_picker.sv | 36 +++
 rtl/sram_arbiter.sv | 139 +++++++++++++
 tb/tb_sram_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p3p_pkg.sv
// Shared types for the SRAM sharing path: signed sample word, SRAM address width, arbiter states.
// No logic here, so no latency or backpressure applies.
package p3p_pkg;

  typedef logic signed [15:0] num;

  localparam int SRAM_ADDR_W = 21;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

endpackage

// File: rtl/sram_arbiter_rr_picker.sv
// rr_picker: combinational round-robin choice, first asserted req at index >= rr_ptr, wrapping.
// Zero latency; no backpressure, the caller samples win/win_vld when it is free to grant.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] win,
  output logic             win_vld,
  output logic [PW-1:0]    win_idx
);

  // Scan from the farthest offset down so the nearest asserted request is written last and wins.
  always_comb begin
    int            s;
    logic [PW-1:0] idx;
    win     = '0;
    win_vld = 1'b0;
    win_idx = '0;
    s       = 0;
    idx     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      s = int'(rr_ptr) + k;
      if (s >= N_REQ) s = s - N_REQ;
      idx = PW'(s);
      if (req[idx]) begin
        win      = '0;
        win[idx] = 1'b1;
        win_vld  = 1'b1;
        win_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin owner of the single SRAM port, one transaction in flight; SRAM_ARB_TIMEOUT_EN adds a ready timeout.
// Strobe 1 cycle after req is seen, done 1 cycle after sram_ready; requesters hold req until done, nothing else stalls.
module sram_arbiter
  import p3p_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = SRAM_ADDR_W,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*16-1:0]     req_wdata,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output num                      rdata,
  output logic                    err,
  output logic [ADDR_W-1:0]       sram_addr,
  output logic [15:0]             sram_wdata,
  output logic                    sram_read,
  output logic                    sram_write,
  input  logic [15:0]             sram_rdata,
  input  logic                    sram_ready
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t        state, state_nxt;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     own_idx;
  logic [PW-1:0]     win_idx;
  logic [N_REQ-1:0]  win;
  logic              win_vld;
  logic              we_q;
  logic              to_hit;

  rr_picker #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_picker (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .win     (win),
    .win_vld (win_vld),
    .win_idx (win_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Strobes and done are decoded from state so a reset drops them on the very next cycle.
  always_comb begin
    state_nxt  = state;
    sram_read  = 1'b0;
    sram_write = 1'b0;
    done       = '0;
    case (state)
      IDLE:  if (win_vld) state_nxt = ISSUE;
      ISSUE: begin
        sram_read  = ~we_q;
        sram_write = we_q;
        state_nxt  = WAIT;
      end
      WAIT:  if (sram_ready || to_hit) state_nxt = DONE;
      DONE:  begin
        done      = grant;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant      <= '0;
      own_idx    <= '0;
      rr_ptr     <= '0;
      we_q       <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      rdata      <= '0;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          grant      <= win;
          own_idx    <= win_idx;
          we_q       <= req_we[win_idx];
          sram_addr  <= req_addr[win_idx*ADDR_W +: ADDR_W];
          sram_wdata <= req_wdata[win_idx*16 +: 16];
        end
        WAIT: begin
          if (sram_ready) begin
            if (!we_q) rdata <= sram_rdata;
          end else if (to_hit) begin
            rdata <= 16'h8000;
          end
        end
        DONE: begin
          grant  <= '0;
          rr_ptr <= (own_idx == PW'(N_REQ - 1)) ? '0 : own_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt;
  logic       to_q;

  // Counter reads k-1 in the k-th WAIT cycle, so the abort lands after TIMEOUT WAIT cycles.
  assign to_hit = (state == WAIT) && (wait_cnt == TO_LAST);
  assign err    = (state == DONE) && to_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      to_q     <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + 8'd1 : 8'd0;
      if (state == ISSUE)                   to_q <= 1'b0;
      else if (to_hit && !sram_ready)       to_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^8'(TIMEOUT);
  assign to_hit         = 1'b0;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: scenario tasks, a simple SRAM responder and a done scoreboard.
// Build with SRAM_ARB_TIMEOUT_EN to also exercise the ready timeout (TIMEOUT=10).
module tb_sram_arbiter;

  localparam int N  = 4;
  localparam int AW = 21;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N-1:0]      req_we = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*16-1:0]   req_wdata = '0;
  logic [N-1:0]      grant;
  logic [N-1:0]      done;
  logic signed [15:0] rdata;
  logic              err;
  logic [AW-1:0]     sram_addr;
  logic [15:0]       sram_wdata;
  logic              sram_read;
  logic              sram_write;
  logic [15:0]       sram_rdata = '0;
  logic              sram_ready = 1'b0;

  sram_arbiter #(
    .N_REQ   (N),
    .ADDR_W  (AW),
    .TIMEOUT (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .grant      (grant),
    .done       (done),
    .rdata      (rdata),
    .err        (err),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_read  (sram_read),
    .sram_write (sram_write),
    .sram_rdata (sram_rdata),
    .sram_ready (sram_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // SRAM responder state and the most recent strobe it saw.
  int            cyc = 0;
  int            strobe_cnt = 0;
  int            overlap_cnt = 0;
  int            sram_lat = 1;
  int            sram_cnt = -1;
  logic          force_ready = 1'b0;
  logic          st_rd = 1'b0;
  logic [AW-1:0] st_addr = '0;
  logic [15:0]   st_wd = '0;
  logic [N-1:0]  st_grant = '0;
  int            st_cyc = 0;
  logic [15:0]   last_rd = '0;

  typedef struct {
    int          idx;
    logic [15:0] rd;
    logic        e;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [15:0] mem_val(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  task automatic push_exp(input int idx, input logic [15:0] rd, input logic e);
    exp_t x;
    x.idx = idx;
    x.rd  = rd;
    x.e   = e;
    exp_q.push_back(x);
  endtask

  // One clock; sample at +1, then update the SRAM model for the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (sram_read || sram_write) begin
      strobe_cnt++;
      if (sram_read && sram_write) overlap_cnt++;
      st_rd    = sram_read;
      st_addr  = sram_addr;
      st_wd    = sram_wdata;
      st_grant = grant;
      st_cyc   = cyc;
      sram_cnt = sram_lat;
      sram_ready = 1'b0;
    end else if (sram_cnt > 0) begin
      sram_cnt--;
      sram_ready = (sram_cnt == 0);
      if (sram_cnt == 0) sram_cnt = -1;
    end else begin
      sram_ready = force_ready;
    end
    sram_rdata = mem_val(sram_addr);
  endtask

  task automatic wait_done(input int budget, output logic ok, output logic [N-1:0] d,
                           output logic [15:0] rd, output logic e, output int at);
    ok = 1'b0; d = '0; rd = '0; e = 1'b0; at = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (done != '0) begin
        ok = 1'b1; d = done; rd = rdata; e = err; at = cyc;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (grant !== '0)      begin n_fail++; $display("FAIL reset_grant: got %b want 0", grant); end
    n_checks++; if (done !== '0)       begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (rdata !== 16'h0)   begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_checks++; if (err !== 1'b0)      begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++; if (sram_addr !== '0)  begin n_fail++; $display("FAIL reset_addr: got %h want 0", sram_addr); end
    n_checks++; if (sram_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", sram_wdata); end
    n_checks++; if ({sram_read, sram_write} !== 2'b00)
      begin n_fail++; $display("FAIL reset_strobe: got %b want 00", {sram_read, sram_write}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    logic ok, e; logic [N-1:0] d; logic [15:0] rd; int at, s0;
    exp_t x;
    req_addr[1*AW +: AW] = 21'h00010;
    req_we   = '0;
    sram_lat = 3;
    push_exp(1, mem_val(21'h00010), 1'b0);
    s0  = strobe_cnt;
    req = 4'b0010;
    wait_done(30, ok, d, rd, e, at);
    req = '0;
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rd_done_seen: got %b want 1", ok); end
    n_checks++; if (strobe_cnt - s0 != 1) begin n_fail++; $display("FAIL rd_strobe_cnt: got %0d want 1", strobe_cnt - s0); end
    n_checks++; if (st_rd !== 1'b1) begin n_fail++; $display("FAIL rd_strobe_kind: got %b want 1", st_rd); end
    n_checks++; if (st_addr !== 21'h00010) begin n_fail++; $display("FAIL rd_addr: got %h want 00010", st_addr); end
    n_checks++; if (st_grant !== 4'b0010) begin n_fail++; $display("FAIL rd_grant: got %b want 0010", st_grant); end
    n_checks++; if (at != st_cyc + 4) begin n_fail++; $display("FAIL rd_latency: got %0d want %0d", at - st_cyc, 4); end
    if (ok) begin
      x = exp_q.pop_front();
      n_checks++; if (d !== 4'(1 << x.idx)) begin n_fail++; $display("FAIL rd_done_idx: got %b want %b", d, 4'(1 << x.idx)); end
      n_checks++; if (rd !== x.rd) begin n_fail++; $display("FAIL rd_rdata: got %h want %h", rd, x.rd); end
      n_checks++; if (e !== x.e) begin n_fail++; $display("FAIL rd_err: got %b want %b", e, x.e); end
      last_rd = x.rd;
    end else exp_q.delete();
    tick();
    n_checks++; if (done !== '0) begin n_fail++; $display("FAIL rd_done_width: got %b want 0", done); end
    n_checks++; if (grant !== '0) begin n_fail++; $display("FAIL rd_grant_clear: got %b want 0", grant); end
    n_checks++; if (rdata !== last_rd) begin n_fail++; $display("FAIL rd_hold: got %h want %h", rdata, last_rd); end
  endtask

  task automatic test_contention();
    logic ok, e; logic [N-1:0] d; logic [15:0] rd; int at, prev, s0, o0;
    int order[5] = '{0, 1, 2, 3, 0};
    exp_t x;
    do_reset();
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = 21'h00100 + AW'(i);
    req_we   = '0;
    sram_lat = 1;
    for (int k = 0; k < 5; k++) push_exp(order[k], mem_val(21'h00100 + AW'(order[k])), 1'b0);
    s0 = strobe_cnt; o0 = overlap_cnt; prev = 0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(20, ok, d, rd, e, at);
      if (k == 4) req = '0;
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL cont_done_seen[%0d]: got %b want 1", k, ok); end
      if (ok) begin
        x = exp_q.pop_front();
        n_checks++; if (d !== 4'(1 << x.idx)) begin n_fail++; $display("FAIL cont_order[%0d]: got %b want %b", k, d, 4'(1 << x.idx)); end
        n_checks++; if (rd !== x.rd) begin n_fail++; $display("FAIL cont_rdata[%0d]: got %h want %h", k, rd, x.rd); end
        if (k > 0) begin
          n_checks++; if (at - prev != 4) begin n_fail++; $display("FAIL cont_spacing[%0d]: got %0d want 4", k, at - prev); end
        end
        prev = at;
        last_rd = x.rd;
      end
    end
    exp_q.delete();
    tick();
    n_checks++; if (overlap_cnt != o0) begin n_fail++; $display("FAIL cont_overlap: got %0d want %0d", overlap_cnt, o0); end
    n_checks++; if (strobe_cnt - s0 != 5) begin n_fail++; $display("FAIL cont_strobes: got %0d want 5", strobe_cnt - s0); end
  endtask

  task automatic test_write();
    logic ok, e; logic [N-1:0] d; logic [15:0] rd; int at;
    exp_t x;
    req_we = 4'b0100;
    req_wdata[2*16 +: 16] = 16'hFF38;
    req_addr[2*AW +: AW]  = 21'h1FFFFE;
    sram_lat = 2;
    push_exp(2, last_rd, 1'b0);
    req = 4'b0100;
    wait_done(20, ok, d, rd, e, at);
    req = '0;
    req_we = '0;
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wr_done_seen: got %b want 1", ok); end
    n_checks++; if (st_rd !== 1'b0) begin n_fail++; $display("FAIL wr_strobe_kind: got read=%b want 0", st_rd); end
    n_checks++; if (st_addr !== 21'h1FFFFE) begin n_fail++; $display("FAIL wr_addr: got %h want 1ffffe", st_addr); end
    n_checks++; if (st_wd !== 16'hFF38) begin n_fail++; $display("FAIL wr_wdata: got %h want ff38", st_wd); end
    if (ok) begin
      x = exp_q.pop_front();
      n_checks++; if (d !== 4'(1 << x.idx)) begin n_fail++; $display("FAIL wr_done_idx: got %b want %b", d, 4'(1 << x.idx)); end
      n_checks++; if (rd !== x.rd) begin n_fail++; $display("FAIL wr_rdata_kept: got %h want %h", rd, x.rd); end
      n_checks++; if (e !== x.e) begin n_fail++; $display("FAIL wr_err: got %b want %b", e, x.e); end
    end else exp_q.delete();
    tick();
  endtask

  task automatic test_latching();
    logic ok, e, seen; logic [N-1:0] d; logic [15:0] rd; int at;
    exp_t x;
    req_addr[0*AW +: AW] = 21'h0ABCD;
    sram_lat = 3;
    push_exp(0, mem_val(21'h0ABCD), 1'b0);
    req = 4'b0001;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = sram_read;
    end
    req_addr[0*AW +: AW] = 21'h15555;
    req = '0;
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL latch_strobe_seen: got %b want 1", seen); end
    tick();
    n_checks++; if (sram_addr !== 21'h0ABCD) begin n_fail++; $display("FAIL latch_addr: got %h want 0abcd", sram_addr); end
    wait_done(20, ok, d, rd, e, at);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL latch_done_seen: got %b want 1", ok); end
    if (ok) begin
      x = exp_q.pop_front();
      n_checks++; if (d !== 4'(1 << x.idx)) begin n_fail++; $display("FAIL latch_done_idx: got %b want %b", d, 4'(1 << x.idx)); end
      n_checks++; if (rd !== x.rd) begin n_fail++; $display("FAIL latch_rdata: got %h want %h", rd, x.rd); end
    end else exp_q.delete();
    tick();
  endtask

  task automatic test_reset_wait();
    logic seen; int s0, ndone;
    req_addr[3*AW +: AW] = 21'h00003;
    sram_lat = -1;
    req = 4'b1000;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = sram_read;
    end
    tick();
    tick();
    reset = 1'b1;
    req = '0;
    tick();
    reset = 1'b0;
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rstw_strobe_seen: got %b want 1", seen); end
    n_checks++; if (grant !== '0) begin n_fail++; $display("FAIL rstw_grant: got %b want 0", grant); end
    n_checks++; if ({sram_read, sram_write} !== 2'b00)
      begin n_fail++; $display("FAIL rstw_strobe: got %b want 00", {sram_read, sram_write}); end
    n_checks++; if (sram_addr !== '0) begin n_fail++; $display("FAIL rstw_addr: got %h want 0", sram_addr); end
    n_checks++; if (rdata !== 16'h0) begin n_fail++; $display("FAIL rstw_rdata: got %h want 0", rdata); end
    s0 = strobe_cnt; ndone = 0;
    force_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done != '0) ndone++;
    end
    force_ready = 1'b0;
    n_checks++; if (ndone != 0) begin n_fail++; $display("FAIL rstw_no_done: got %0d want 0", ndone); end
    n_checks++; if (strobe_cnt != s0) begin n_fail++; $display("FAIL rstw_no_strobe: got %0d want %0d", strobe_cnt, s0); end
    sram_lat = 1;
    tick();
  endtask

`ifdef SRAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic ok, e; logic [N-1:0] d; logic [15:0] rd; int at;
    exp_t x;
    do_reset();
    req_addr[1*AW +: AW] = 21'h00041;
    req_addr[2*AW +: AW] = 21'h00042;
    req_we   = '0;
    sram_lat = -1;
    push_exp(1, 16'h8000, 1'b1);
    push_exp(2, 16'h8000, 1'b1);
    req = 4'b0110;
    for (int k = 0; k < 2; k++) begin
      wait_done(40, ok, d, rd, e, at);
      if (k == 0) req = 4'b0100;
      else        req = '0;
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL to_done_seen[%0d]: got %b want 1", k, ok); end
      if (ok) begin
        x = exp_q.pop_front();
        n_checks++; if (d !== 4'(1 << x.idx)) begin n_fail++; $display("FAIL to_done_idx[%0d]: got %b want %b", k, d, 4'(1 << x.idx)); end
        n_checks++; if (e !== x.e) begin n_fail++; $display("FAIL to_err[%0d]: got %b want %b", k, e, x.e); end
        n_checks++; if (rd !== x.rd) begin n_fail++; $display("FAIL to_rdata[%0d]: got %h want %h", k, rd, x.rd); end
        n_checks++; if (at != st_cyc + 11) begin n_fail++; $display("FAIL to_latency[%0d]: got %0d want 11", k, at - st_cyc); end
      end
    end
    exp_q.delete();
    tick();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_err_width: got %b want 0", err); end
    sram_lat = 1;
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write();
    test_latching();
    test_reset_wait();
`ifdef SRAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
